mul_seq: RTL

- Parametrised N x N iterative multiplier producing a 2N-bit product.
- Each operand's signedness is selected independently per operation, so it covers unsigned, signed and mixed products.
- Consumes one partial product per clock; uses valid/ready handshakes on input and output.
- Sits beside the combinational multipliers as the area-cheap option for datapaths that can tolerate N-cycle latency.

---
 rtl/mul_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Iterative N x N shift-add multiplier with per-operand signedness select.
// One partial product per clock; valid/ready on both sides, zero-bubble restart from DONE.
module mul_seq #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sa,
  input  logic           sb,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z,
  output logic           busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  logic [1:0]     state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] a_sh;
  logic [N-1:0]   b_sh;
  logic           sb_r;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           last;
  logic [2*N-1:0] term;
  logic [2*N-1:0] acc_nxt;

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);

  // a_sh already carries the shift for the current step; b's MSB weighs -2^(N-1) when signed
  always_comb begin
    term    = b_sh[0] ? a_sh : '0;
    last    = (cnt == LAST);
    acc_nxt = (last && sb_r) ? (acc - term) : (acc + term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      sb_r  <= 1'b0;
      cnt   <= '0;
      z     <= '0;
    end else begin
      case (state)
        S_BUSY: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          if (last) begin
            z     <= acc_nxt;
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready && !in_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // accept can only fire from IDLE or DONE, so it never collides with BUSY updates
      if (accept) begin
        a_sh  <= sa ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        b_sh  <= b;
        sb_r  <= sb;
        acc   <= '0;
        cnt   <= '0;
        state <= S_BUSY;
      end
    end
  end

endmodule
